// File: rtl/seg_scan_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | seg_scan_pkg : shared types and helpers for the digit scanner   |
// | Revision     : 1.0                                              |
// +-----------------------------------------------------------------+
package seg_scan_pkg;

  localparam int NUM_DIGITS = 8;

  typedef logic [3:0]                 digit_t;
  typedef logic [2:0]                 sel_t;
  typedef digit_t [NUM_DIGITS-1:0]    digit_buf_t;

  // Bit i set when digit i and every digit above it are zero; digit 0 is never flagged.
  function automatic logic [NUM_DIGITS-1:0] lz_mask(input digit_buf_t digits);
    logic [NUM_DIGITS-1:0] mask;
    logic                  zero_above;
    mask       = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & (digits[i] == 4'h0);
      mask[i]    = zero_above;
    end
    return mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_scan_if.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | seg_scan_if : write/commit/enable inputs and decoder outputs    |
// | Revision    : 1.0                                               |
// +-----------------------------------------------------------------+
interface seg_scan_if;
  import seg_scan_pkg::*;

  logic                  wr_en;
  sel_t                  wr_addr;
  digit_t                wr_data;
  logic                  commit;
  logic [NUM_DIGITS-1:0] digit_en;
  digit_t                num;
  sel_t                  sel;
  logic                  blank;
  logic                  pending;
  logic                  frame_tick;

  modport master (
    output wr_en, wr_addr, wr_data, commit, digit_en,
    input  num, sel, blank, pending, frame_tick
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, commit, digit_en,
    output num, sel, blank, pending, frame_tick
  );

endinterface
`default_nettype wire

// File: rtl/seg_scan_prescaler.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | seg_scan_prescaler : 0..REFRESH_DIV-1 counter, step on last     |
// | Revision           : 1.0                                        |
// +-----------------------------------------------------------------+
module seg_scan_prescaler #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  output logic step
);

  localparam int            CW   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] pcnt_q;
  logic [CW-1:0] pcnt_d;

  assign step   = (pcnt_q == LAST);
  assign pcnt_d = step ? '0 : pcnt_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | seg_scan_ctrl : double-buffered 8-digit refresh scanner         |
// | Option        : SEG_SCAN_LZB_EN enables leading-zero blanking   |
// | Revision      : 1.0                                             |
// +-----------------------------------------------------------------+
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  seg_scan_if.slave  bus
);

  logic step;

  seg_scan_prescaler #(
    .REFRESH_DIV (REFRESH_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .step (step)
  );

  sel_t                  sel_q, sel_d;
  logic                  pending_q, pending_d;
  digit_buf_t            shadow_q, shadow_d;
  digit_buf_t            active_q, active_d;
  digit_t                num_q, num_d;
  logic                  blank_q, blank_d;
  logic                  frame_tick_q, frame_tick_d;
  logic                  wrap;
  logic                  apply;
  logic [NUM_DIGITS-1:0] lzb_mask;

`ifdef SEG_SCAN_LZB_EN
  assign lzb_mask = lz_mask(active_d);
`else
  assign lzb_mask = '0;
`endif

  // Outputs are built from the next-state buffer and index so num/sel/blank stay coherent.
  always_comb begin
    sel_d    = step ? sel_q + 3'd1 : sel_q;
    wrap     = step && (sel_q == 3'd7);

    shadow_d = shadow_q;
    if (bus.wr_en) begin
      shadow_d[bus.wr_addr] = bus.wr_data;
    end

    apply        = wrap && (pending_q || bus.commit);
    active_d     = apply ? shadow_d : active_q;
    pending_d    = !apply && (pending_q || bus.commit);

    num_d        = active_d[sel_d];
    blank_d      = !bus.digit_en[sel_d] || lzb_mask[sel_d];
    frame_tick_d = wrap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q        <= '0;
      pending_q    <= 1'b0;
      shadow_q     <= '0;
      active_q     <= '0;
      num_q        <= '0;
      blank_q      <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      sel_q        <= sel_d;
      pending_q    <= pending_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      num_q        <= num_d;
      blank_q      <= blank_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign bus.num        = num_q;
  assign bus.sel        = sel_q;
  assign bus.blank      = blank_q;
  assign bus.pending    = pending_q;
  assign bus.frame_tick = frame_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_seg_scan_ctrl : scoreboard bench for seg_scan_ctrl, DIV = 4  |
// | Revision         : 1.0                                          |
// +-----------------------------------------------------------------+
module tb_seg_scan_ctrl;
  import seg_scan_pkg::*;

  localparam int DIV        = 4;
  localparam int FRAME      = 8 * DIV;
`ifdef SEG_SCAN_LZB_EN
  localparam bit LZB        = 1'b1;
`else
  localparam bit LZB        = 1'b0;
`endif

  typedef struct packed {
    digit_t num;
    sel_t   sel;
    logic   blank;
    logic   pending;
    logic   frame_tick;
  } obs_t;

  localparam obs_t RESET_OBS = '{num: 4'h0, sel: 3'd0, blank: 1'b1, pending: 1'b0, frame_tick: 1'b0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg_scan_if bus ();

  seg_scan_ctrl #(
    .REFRESH_DIV (DIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  obs_t act;
  assign act = {bus.num, bus.sel, bus.blank, bus.pending, bus.frame_tick};

  obs_t   exp_q[$];
  int     n_cmp = 0;
  int     n_bad = 0;

  digit_t m_shadow[NUM_DIGITS];
  digit_t m_active[NUM_DIGITS];
  logic   m_pending;
  int     m_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s t=%0d: got %0h, expected %0h", name, m_t, got, want);
    end
  endtask

  task automatic model_reset();
    m_t       = 0;
    m_pending = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      m_shadow[i] = '0;
      m_active[i] = '0;
    end
    exp_q.delete();
  endtask

  function automatic bit lz_blank(input int i);
    if (!LZB || i == 0) return 1'b0;
    for (int j = i; j < NUM_DIGITS; j++) begin
      if (m_active[j] != 4'h0) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Expected output after the edge ending cycle m_t, timed from a free-running cycle index.
  task automatic model_push();
    obs_t e;
    bit   wrap;
    int   sel_n;
    wrap  = ((m_t % FRAME) == FRAME - 1);
    sel_n = ((m_t + 1) / DIV) % NUM_DIGITS;
    if (bus.wr_en) m_shadow[bus.wr_addr] = bus.wr_data;
    if (wrap && (m_pending || bus.commit)) begin
      m_active  = m_shadow;
      m_pending = 1'b0;
    end else begin
      m_pending = m_pending | bus.commit;
    end
    e.num        = m_active[sel_n];
    e.sel        = sel_t'(sel_n);
    e.blank      = !bus.digit_en[sel_n] || lz_blank(sel_n);
    e.pending    = m_pending;
    e.frame_tick = wrap;
    exp_q.push_back(e);
    m_t++;
  endtask

  task automatic cyc(input logic we = 1'b0, input int addr = 0, input int data = 0, input logic cm = 1'b0);
    bus.wr_en   = we;
    bus.wr_addr = sel_t'(addr);
    bus.wr_data = digit_t'(data);
    bus.commit  = cm;
    model_push();
    @(posedge clk);
    #2;
  endtask

  task automatic run_to(input int phase);
    while ((m_t % FRAME) != phase) cyc();
  endtask

  always begin : monitor
    obs_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (act !== e) begin
        n_bad++;
        $display("FAIL scoreboard t=%0d: got num=%h sel=%0d blank=%b pend=%b ft=%b, expected num=%h sel=%0d blank=%b pend=%b ft=%b",
                 m_t, act.num, act.sel, act.blank, act.pending, act.frame_tick,
                 e.num, e.sel, e.blank, e.pending, e.frame_tick);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.commit   = 1'b0;
    bus.digit_en = 8'hFF;
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("reset_state", act, RESET_OBS);
    rst = 1'b0;
    model_reset();

    // Free run: sel steps every DIV cycles, frame_tick every FRAME cycles
    repeat (40) cyc();
    check("free_run_sel", bus.sel, 3'd2);

    // Shadow writes without commit never reach the display
    for (int i = 0; i < NUM_DIGITS; i++) cyc(1'b1, i, i);
    repeat (3 * FRAME) cyc();
    check("no_commit_pending", bus.pending, 1'b0);
    check("no_commit_num", bus.num, 4'h0);

    // Commit mid-frame, applied at the following wrap
    run_to(0);
    repeat (10) cyc();
    cyc(1'b0, 0, 0, 1'b1);
    repeat (3) cyc();
    check("commit_pending_set", bus.pending, 1'b1);
    run_to(0);
    check("commit_applied_pending", bus.pending, 1'b0);
    check("commit_frame_tick", bus.frame_tick, 1'b1);
    for (int k = 0; k < NUM_DIGITS; k++) begin
      check("commit_sel", bus.sel, k);
      check("commit_num_eq_sel", bus.num, k);
      repeat (DIV) cyc();
    end

    // Commit and write together in the wrap cycle
    run_to(FRAME - 1);
    cyc(1'b1, 0, 4'hA, 1'b1);
    check("wrap_commit_num", bus.num, 4'hA);
    check("wrap_commit_pending", bus.pending, 1'b0);
    check("wrap_commit_sel", bus.sel, 3'd0);

    // Per-digit enable, including a mid-hold toggle
    bus.digit_en = 8'h0F;
    repeat (FRAME) cyc();
    run_to(5);
    bus.digit_en = 8'h0D;
    cyc();
    check("en_toggle_off", bus.blank, 1'b1);
    bus.digit_en = 8'h0F;
    cyc();
    check("en_toggle_on", bus.blank, 1'b0);
    run_to(4 * DIV + 1);
    check("en_high_blank", bus.blank, 1'b1);

    // Active = 32'h0000_00A0: leading-zero blanking when compiled in
    bus.digit_en = 8'hFF;
    for (int i = 0; i < NUM_DIGITS; i++) cyc(1'b1, i, (i == 1) ? 4'hA : 4'h0);
    cyc(1'b0, 0, 0, 1'b1);
    run_to(0);
    check("lzb_d0_blank", bus.blank, 1'b0);
    repeat (DIV) cyc();
    check("lzb_d1_num", bus.num, 4'hA);
    repeat (DIV) cyc();
    check("lzb_d2_blank", bus.blank, LZB);
    repeat (FRAME) cyc();

    // All-zero active: only digit 0 stays lit under blanking
    cyc(1'b1, 1, 0);
    cyc(1'b0, 0, 0, 1'b1);
    run_to(0);
    check("zero_d0_blank", bus.blank, 1'b0);
    repeat (DIV) cyc();
    check("zero_d1_blank", bus.blank, LZB);
    repeat (FRAME) cyc();

    // Asynchronous reset mid-frame with a commit outstanding
    run_to(8);
    cyc(1'b1, 3, 4'h5, 1'b1);
    repeat (3) cyc();
    check("pre_reset_pending", bus.pending, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    check("async_reset_state", act, RESET_OBS);
    exp_q.delete();
    @(posedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    repeat (2 * FRAME) cyc();
    check("post_reset_pending", bus.pending, 1'b0);
    check("post_reset_num", bus.num, 4'h0);

    @(posedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed refresh controller for the 8-digit seven-segment display. It sits upstream of the combinational hex-to-segment decoder and drives that decoder's 4-bit `num` and 3-bit `sel` inputs. It holds eight hex digits in a double buffer: writers fill a shadow buffer, and a commit copies it into the active buffer only at a frame boundary, so the display never tears. It rotates `sel` at a programmable rate.

## Interface
- `REFRESH_DIV`, default 100000: clock cycles each digit is held (1 kHz/digit at 100 MHz). Minimum 2.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `wr_en`  in  1: write `wr_data` into shadow digit `wr_addr` this cycle.
- `wr_addr`  in  3: shadow digit index, 0 = rightmost.
- `wr_data`  in  4: hex digit value.
- `commit`  in  1: single-cycle request to copy shadow→active at the next frame boundary.
- `digit_en`  in  8: per-digit enable; a disabled digit is blanked.
- `num`  out  4: digit value to the decoder.
- `sel`  out  3: digit index to the decoder.
- `blank`  out  1: current digit must be dark; top level forces all anodes off when set.
- `pending`  out  1: commit requested, not yet applied.
- `frame_tick`  out  1: one-cycle pulse, asserted with the first cycle of `sel`=0 after a wrap.

## Operation
- Prescaler `pcnt` counts 0..REFRESH_DIV-1 and wraps. The cycle with `pcnt`=REFRESH_DIV-1 is a step cycle.
- Step cycle: `sel_next` = `sel`+1 mod 8. On all other cycles `sel_next` = `sel`.
- Wrap = a step cycle with `sel`=7.
- Shadow write: on `wr_en`, `shadow[wr_addr]` ← `wr_data`. Writes are always accepted, including while `pending` is set.
- Commit:
  - `commit` sets `pending`. A `commit` while `pending` is already set has no further effect.
  - On a wrap cycle with (`pending` | `commit`), active ← shadow including any same-cycle write, and `pending` ← 0.
- Outputs are registered and recomputed every cycle from the next-state values, so `num`, `sel` and `blank` always agree:
  - `num` ← `active_next[sel_next]`.
  - `blank` ← ~`digit_en[sel_next]`.
- `frame_tick` ← 1 on the edge ending a wrap cycle, 0 otherwise.
- Reset values:
  - `pcnt`=0, `sel`=0, `num`=0, `blank`=1, `pending`=0, `frame_tick`=0.
  - Shadow and active buffers all 0.
- Reset mid-frame or mid-commit discards the pending request and buffer contents.

## Timing
- Digit hold time: REFRESH_DIV cycles. Frame period: 8×REFRESH_DIV cycles.
- First `sel` change after reset release: edge ending cycle REFRESH_DIV.
- Write-to-display latency: applied at the next wrap after commit, worst case 8×REFRESH_DIV cycles. Output is visible 1 cycle after the wrap edge, with `sel`=0 and `frame_tick`=1.
- Commit and wrap in the same cycle: copy applies at that edge, and `pending` never becomes visible as 1.
- `digit_en` change: reflected in `blank` 1 cycle later, without waiting for a frame boundary.
- Prescaler width: $clog2(REFRESH_DIV). No overflow beyond REFRESH_DIV-1.

## Configuration
- `SEG_SCAN_LZB_EN` defined: leading-zero blanking is compiled in.
  - Digit i is also blanked when `active[i]`=0 and `active[j]`=0 for all j>i.
  - Digit 0 is never blanked by this rule, so the value 0 displays as a single "0".
  - Evaluated on `active_next`, so it takes effect in the same cycle as a commit.
- Undefined: only `digit_en` controls `blank`, and leading zeros are displayed.

## Structure
- Package `seg_scan_pkg` holds:
  - `NUM_DIGITS`=8.
  - `digit_t` (logic [3:0]).
  - `sel_t` (logic [2:0]).
  - `digit_buf_t` (digit_t [NUM_DIGITS-1:0]).
- Sub-module `seg_scan_prescaler`: parameter REFRESH_DIV, ports `clk` and `rst`, output `step` pulse. All other logic lives in `seg_scan_ctrl`.

## Test plan
All scenarios use REFRESH_DIV=4.
- Reset then free run with `digit_en`=8'hFF → `sel` steps 0,1,…,7,0 every 4 cycles. `num`=0 and `blank`=0 after the first cycle. `frame_tick` pulses every 32 cycles.
- Write 8 digits {7,6,5,4,3,2,1,0} (addr 7 = 7, …, addr 0 = 0) with no commit → `num` stays 0 for 3 frames and `pending`=0.
- Write the same digits, then `commit` at cycle 10 → `pending`=1 until the wrap edge at cycle 32. From cycle 32, `num` equals `sel` in every cycle.
- `commit` asserted exactly in a wrap cycle together with `wr_en` (addr 0, data A) → active digit 0 = A at that edge, and `pending` stays 0.
- `digit_en`=8'h0F → `blank`=1 exactly while `sel`∈{4..7}. Toggle `digit_en[1]` mid-hold → `blank` follows 1 cycle later.
- With `SEG_SCAN_LZB_EN`, commit active=32'h0000_00A0 → digits 7..2 blanked, digit 1 shows A, digit 0 shows 0. Commit all-zero → only digit 0 is unblanked.
- Assert `rst` mid-frame with `pending`=1 → all outputs return to their reset values asynchronously. After release, `pending`=0 and `num`=0.
